// File: rtl/linebuf_pingpong.sv
// linebuf_pingpong: double-buffered scanline store with transparency-priority render writes and read-and-erase scan-out
module linebuf_pingpong #(
  parameter int AW = 9,
  parameter int DW = 11,
  parameter logic [DW-1:0] CLRV = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic          pix_ce,
  input  logic          active,
  input  logic          rnd_req,
  input  logic [AW-1:0] rnd_adr,
  input  logic [DW-1:0] rnd_dat,
  output logic          rnd_ack,
  output logic          rnd_coll,
  output logic          bank,
  output logic [DW-1:0] pix_out,
  output logic          pix_valid
);
  typedef enum logic [1:0] {R_IDLE, R_RD, R_WR} rstate_t;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP} sstate_t;
  rstate_t rs, rs_n;
  sstate_t ss, ss_n;
  logic [DW-1:0] mem [2][2**AW];
  logic [AW-1:0] ra, sx, x;
  logic [DW-1:0] rd, qa, qb;
  logic tgt, sbank, r_go, s_go, keep, hit;
  always_comb begin
    r_go = rs == R_IDLE && rnd_req && !rnd_ack;
    s_go = ss == S_IDLE && pix_ce && active;
    keep = qa[3:0] != 4'd0;
    hit  = rs == R_WR && keep && rd[3:0] != 4'd0;
    rs_n = r_go ? R_RD : rs == R_RD ? R_WR : R_IDLE;
    ss_n = s_go ? S_RD : ss == S_RD ? S_CAP : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs        <= R_IDLE;
      ss        <= S_IDLE;
      bank      <= 1'b0;
      rnd_ack   <= 1'b0;
      rnd_coll  <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      x         <= '0;
    end else begin
      rs        <= rs_n;
      ss        <= ss_n;
      rnd_ack   <= rs == R_WR;
      pix_valid <= ss == S_CAP;
      if (ss == S_CAP) pix_out <= qb;
      if (line_start) bank <= ~bank;
      rnd_coll  <= hit | (rnd_coll & ~line_start);
      // x advances at acceptance; the in-flight access keeps its own copy in sx
      x         <= line_start ? '0 : s_go ? x + 1'b1 : x;
    end
  end
  // Port A belongs to the render engine, port B to the scan engine; banks never collide
  always_ff @(posedge clk) begin
    if (r_go) begin
      ra  <= rnd_adr;
      rd  <= rnd_dat;
      tgt <= bank;
    end
    if (s_go) begin
      sx    <= x;
      sbank <= ~bank;
    end
    if (rs == R_WR && !keep) mem[tgt][ra] <= rd;
    if (ss == S_CAP) mem[sbank][sx] <= CLRV;
    qa <= mem[tgt][ra];
    qb <= mem[sbank][sx];
  end
endmodule
